// File: rtl/johnson_decoder.sv
// Johnson code decoder: phase index, lock tracking, lap and fault counters.
// Define JOHNSON_DEC_HOLD_EN to accept a repeated code as a legal hold.
module johnson_decoder #(
   parameter int LAP_W      = 8,
   parameter int ERR_W      = 8,
   parameter int LOCK_STEPS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       inBus,
   input  logic             en,
   input  logic             clr,
   output logic [2:0]       phase,
   output logic             legal,
   output logic             locked,
   output logic             stepErr,
   output logic             wrap,
   output logic [LAP_W-1:0] lapCount,
   output logic [ERR_W-1:0] errCount
);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           st_q, st_d;
   logic [2:0]       lock_cnt_q, lock_cnt_d;
   logic [3:0]       prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic [2:0]       phase_q, phase_d;
   logic             legal_q, legal_d;
   logic             step_err_q, step_err_d;
   logic             wrap_q, wrap_d;
   logic [LAP_W-1:0] lap_q, lap_d;
   logic [ERR_W-1:0] err_q, err_d;

   // Returns {legal, index}
   function automatic logic [3:0] dec(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'b0000: r = 4'b1000;
         4'b0001: r = 4'b1001;
         4'b0011: r = 4'b1010;
         4'b0111: r = 4'b1011;
         4'b1111: r = 4'b1100;
         4'b1110: r = 4'b1101;
         4'b1100: r = 4'b1110;
         4'b1000: r = 4'b1111;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   logic [3:0] in_dec;
   logic [3:0] pv_dec;
   logic [2:0] nxt_idx;
   logic [2:0] cnt_inc;
   logic       adv;
   logic       hold_ok;
   logic       bad;

   assign in_dec  = dec(inBus);
   assign pv_dec  = dec(prev_q);
   assign nxt_idx = pv_dec[2:0] + 3'd1;
   assign cnt_inc = lock_cnt_q + 3'd1;
   assign adv     = in_dec[3] & pv_dec[3] & (in_dec[2:0] == nxt_idx);

`ifdef JOHNSON_DEC_HOLD_EN
   assign hold_ok = in_dec[3] & (inBus == prev_q);
`else
   assign hold_ok = 1'b0;
`endif

   assign bad = ~adv & ~hold_ok;

   always_comb begin
      st_d         = st_q;
      lock_cnt_d   = lock_cnt_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      phase_d      = phase_q;
      legal_d      = legal_q;
      step_err_d   = 1'b0;
      wrap_d       = 1'b0;
      lap_d        = lap_q;
      err_d        = err_q;
      if (en) begin
         prev_d       = inBus;
         prev_valid_d = 1'b1;
         legal_d      = in_dec[3];
         if (in_dec[3]) phase_d = in_dec[2:0];
         if (prev_valid_q) begin
            unique case (st_q)
               SEARCH: begin
                  if (adv) begin
                     if (cnt_inc == 3'(LOCK_STEPS)) begin
                        st_d       = LOCKED;
                        lock_cnt_d = 3'd0;
                     end else begin
                        lock_cnt_d = cnt_inc;
                     end
                  end else if (bad) begin
                     lock_cnt_d = 3'd0;
                  end
               end
               LOCKED: begin
                  if (bad) begin
                     step_err_d = 1'b1;
                     st_d       = SEARCH;
                     lock_cnt_d = 3'd0;
                     if (err_q != '1) err_d = err_q + ERR_W'(1);
                  end else if (adv && prev_q == 4'b1000) begin
                     wrap_d = 1'b1;
                     lap_d  = lap_q + LAP_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
      // Clear beats any same-edge increment
      if (clr) begin
         lap_d = '0;
         err_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q         <= SEARCH;
         lock_cnt_q   <= 3'd0;
         prev_q       <= 4'd0;
         prev_valid_q <= 1'b0;
         phase_q      <= 3'd0;
         legal_q      <= 1'b0;
         step_err_q   <= 1'b0;
         wrap_q       <= 1'b0;
         lap_q        <= '0;
         err_q        <= '0;
      end else begin
         st_q         <= st_d;
         lock_cnt_q   <= lock_cnt_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         phase_q      <= phase_d;
         legal_q      <= legal_d;
         step_err_q   <= step_err_d;
         wrap_q       <= wrap_d;
         lap_q        <= lap_d;
         err_q        <= err_d;
      end
   end

   assign phase    = phase_q;
   assign legal    = legal_q;
   assign locked   = (st_q == LOCKED);
   assign stepErr  = step_err_q;
   assign wrap     = wrap_q;
   assign lapCount = lap_q;
   assign errCount = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: directed plan plus random stimulus
// checked against a behavioural model of the Johnson sequence rules.
module tb_johnson_decoder;

   localparam int LAP_W   = 8;
   localparam int ERR_W   = 3;
   localparam int LOCK    = 3;
   localparam int LAP_MOD = 1 << LAP_W;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef JOHNSON_DEC_HOLD_EN
   localparam bit HOLD_OK = 1'b1;
`else
   localparam bit HOLD_OK = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [3:0]       inBus;
   logic             en;
   logic             clr;
   logic [2:0]       phase;
   logic             legal;
   logic             locked;
   logic             stepErr;
   logic             wrap;
   logic [LAP_W-1:0] lapCount;
   logic [ERR_W-1:0] errCount;

   johnson_decoder #(
      .LAP_W     (LAP_W),
      .ERR_W     (ERR_W),
      .LOCK_STEPS(LOCK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .inBus   (inBus),
      .en      (en),
      .clr     (clr),
      .phase   (phase),
      .legal   (legal),
      .locked  (locked),
      .stepErr (stepErr),
      .wrap    (wrap),
      .lapCount(lapCount),
      .errCount(errCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       phase;
      logic             legal;
      logic             locked;
      logic             step_err;
      logic             wrap;
      logic [LAP_W-1:0] lap;
      logic [ERR_W-1:0] err;
   } obs_t;

   obs_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   int codes[8] = '{0, 1, 3, 7, 15, 14, 12, 8};

   // Behavioural model state
   int m_prev, m_pv, m_locked, m_run, m_phase, m_legal;
   int m_lap, m_err, m_se, m_wr;
   int last_code;

   function automatic int idx_of(input int c);
      for (int i = 0; i < 8; i++)
         if (codes[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_prev = 0; m_pv = 0; m_locked = 0; m_run = 0;
      m_phase = 0; m_legal = 0; m_lap = 0; m_err = 0;
      m_se = 0; m_wr = 0;
   endtask

   task automatic model_step(input bit e, input bit c, input int code);
      int ci, pi;
      bit adv, hold;
      m_se = 0;
      m_wr = 0;
      if (e) begin
         ci = idx_of(code);
         if (m_pv != 0) begin
            pi   = idx_of(m_prev);
            adv  = (pi >= 0) && (ci >= 0) && (ci == (pi + 1) % 8);
            hold = HOLD_OK && (ci >= 0) && (code == m_prev);
            if (m_locked == 0) begin
               if (adv) begin
                  m_run++;
                  if (m_run == LOCK) begin
                     m_locked = 1;
                     m_run    = 0;
                  end
               end else if (!hold) begin
                  m_run = 0;
               end
            end else if (!adv && !hold) begin
               m_se     = 1;
               m_err    = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
               m_locked = 0;
               m_run    = 0;
            end else if (adv && pi == 7) begin
               m_wr  = 1;
               m_lap = (m_lap + 1) % LAP_MOD;
            end
         end
         m_prev  = code;
         m_pv    = 1;
         m_legal = (ci >= 0);
         if (ci >= 0) m_phase = ci;
      end
      if (c) begin
         m_lap = 0;
         m_err = 0;
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.phase    = 3'(m_phase);
      o.legal    = (m_legal != 0);
      o.locked   = (m_locked != 0);
      o.step_err = (m_se != 0);
      o.wrap     = (m_wr != 0);
      o.lap      = LAP_W'(m_lap);
      o.err      = ERR_W'(m_err);
      return o;
   endfunction

   task automatic step(input bit e, input bit c, input int code);
      @(negedge clk);
      en    = e;
      clr   = c;
      inBus = 4'(code);
      model_step(e, c, code);
      q_exp.push_back(model_obs());
      if (e) last_code = code;
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.phase    = phase;
      o.legal    = legal;
      o.locked   = locked;
      o.step_err = stepErr;
      o.wrap     = wrap;
      o.lap      = lapCount;
      o.err      = errCount;
      return o;
   endfunction

   // Monitor: one DUT observation per edge while expectations are queued
   always @(posedge clk) begin
      obs_t e, a;
      #1;
      if (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         a = dut_obs();
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL step t=%0t got ph=%0d lg=%0b lk=%0b se=%0b wr=%0b lap=%0d err=%0d want ph=%0d lg=%0b lk=%0b se=%0b wr=%0b lap=%0d err=%0d",
                     $time, a.phase, a.legal, a.locked, a.step_err, a.wrap,
                     a.lap, a.err, e.phase, e.legal, e.locked, e.step_err,
                     e.wrap, e.lap, e.err);
         end
      end
   end

   task automatic check_zero(input string name);
      obs_t a;
      a = dut_obs();
      n_tests++;
      if (a !== '0) begin
         n_fail++;
         $display("FAIL %s got %h want 0", name, a);
      end
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      @(negedge clk);
      en  = 1'b0;
      clr = 1'b0;
      rst = 1'b1;
   endtask

   task automatic lock_seq();
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 3);
      step(1, 0, 7);
   endtask

   task automatic rand_step();
      int r, i, code;
      bit e, c;
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 99);
      i = idx_of(last_code);
      if (r < 70)
         code = (i >= 0) ? codes[(i + 1) % 8] : codes[$urandom_range(0, 7)];
      else if (r < 80)
         code = last_code;
      else if (r < 90)
         code = $urandom_range(0, 15);
      else
         code = codes[$urandom_range(0, 7)];
      step(e, c, code);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; clr = 1'b0; inBus = 4'd0;
      last_code = 0;
      model_reset();
      @(negedge clk);
      check_zero("reset_state");
      rst = 1'b1;

      // Lock, then one full lap
      lock_seq();
      step(1, 0, 15); step(1, 0, 14); step(1, 0, 12);
      step(1, 0, 8);  step(1, 0, 0);
      // Illegal code while locked, then relock
      step(1, 0, 1); step(1, 0, 3); step(1, 0, 5);
      lock_seq();
      // Clear on the wrap edge
      step(1, 0, 15); step(1, 0, 14); step(1, 0, 12);
      step(1, 0, 8);  step(1, 1, 0);
      // Skip, then hold
      step(1, 0, 1); step(1, 0, 3); step(1, 0, 15);
      lock_seq();
      step(1, 0, 7); step(1, 0, 7);
      // Saturate the fault counter
      for (int k = 0; k < 10; k++) begin
         lock_seq();
         step(1, 0, 9);
      end
      // Enable-gated edges
      step(0, 0, 5); step(0, 1, 3);
      // Five laps, then async reset mid-revolution
      step(1, 1, 0);
      lock_seq();
      for (int k = 0; k < 5; k++)
         for (int j = 4; j < 12; j++) step(1, 0, codes[j % 8]);
      step(1, 0, 1); step(1, 0, 3);
      async_reset();
      step(1, 0, 3); step(1, 0, 7); step(1, 0, 15);

      for (int k = 0; k < 3000; k++) rand_step();
      async_reset();
      step(1, 0, 12);
      for (int k = 0; k < 1000; k++) rand_step();

      repeat (3) @(posedge clk);
      #2;
      n_tests++;
      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d want 0", q_exp.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
